airlock_cycle_ctrl: RTL and testbench
=====================================

// Module: airlock_cycle_ctrl
// PURPOSE
//  Parametrised airlock chamber controller; successor to the single-mode evacuate FSM.
//  Runs evacuate or pressurize cycles with door interlocks, minimum pump/vent time,
//  timeout fault detection, abort and fault clear. Sits between door/pressure sensors
//  and the pump/valve drivers.
// PARAMETERS
//  CNT_W         8   width of the internal cycle counter
//  MIN_CYCLES    4   minimum cycles pump/valve stays on before the sensor is honoured (>=1)
//  TIMEOUT_CYC   16  total cycles in EVAC/PRESS before FAULT (> MIN_CYCLES, < 2**CNT_W)
// PORTS
//  Clock             in   1   system clock, rising edge
//  Reset             in   1   synchronous, active-high reset
//  begin_Evacuation  in   1   request evacuate cycle (level, sampled in IDLE)
//  begin_Pressurize  in   1   request pressurize cycle (level, sampled in IDLE)
//  InnerClosed       in   1   inner door closed sensor
//  OuterClosed       in   1   outer door closed sensor
//  Evacuated         in   1   chamber-at-vacuum sensor (0 = pressurized)
//  Abort             in   1   cancel active cycle
//  ClearFault        in   1   leave FAULT state
//  PumpOn            out  1   vacuum pump drive
//  ValveOpen         out  1   vent valve drive
//  Busy              out  1   cycle in progress (EVAC or PRESS)
//  Done              out  1   one-cycle pulse on successful completion
//  Reject            out  1   one-cycle pulse when a request is refused
//  Fault             out  1   held high while in FAULT
//  cycle_count       out  16  completed-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered; Reset forces state IDLE, counter 0, every output 0.
//  - Reset mid-cycle: IDLE next edge, PumpOn/ValveOpen drop, no Done, no Fault.
//  - States: IDLE, EVAC, PRESS, DONE, FAULT.
//  - IDLE: begin_Evacuation=1 & begin_Pressurize=0 & InnerClosed & OuterClosed & !Evacuated
//    -> EVAC; begin_Pressurize=1 & begin_Evacuation=0 & both doors closed & Evacuated -> PRESS.
//    Both requests high, any door open, or chamber already in target condition -> stay IDLE,
//    Reject=1 for exactly one cycle (re-pulses every cycle the refused request stays high).
//  - Entry to EVAC/PRESS clears counter; PumpOn (EVAC) / ValveOpen (PRESS) and Busy are 1
//    from the first cycle in the state. Never both PumpOn and ValveOpen.
//  - Counter increments each cycle in EVAC/PRESS, no wrap (bounded by TIMEOUT_CYC).
//  - EVAC exit priority per cycle: Abort -> IDLE; either door open -> FAULT;
//    counter >= MIN_CYCLES-1 & Evacuated -> DONE; counter == TIMEOUT_CYC-1 -> FAULT.
//    PRESS identical with completion condition !Evacuated.
//  - Abort and door-open same cycle: Abort wins (IDLE, no Fault).
//  - Sensor reaching target before MIN_CYCLES: ignored until minimum time elapses.
//  - DONE: one cycle, Done=1, drives off, -> IDLE unconditionally.
//  - FAULT: Fault=1, drives off; ClearFault=1 -> IDLE; requests ignored, no Reject.
//  - Min latency request->Done: MIN_CYCLES+1 edges after request sampled.
// CONFIGURATION
//  AIRLOCK_CYCLE_COUNT_EN defined: cycle_count increments by 1 on each entry to DONE,
//    saturates at 16'hFFFF, cleared only by Reset.
//  Not defined: counter logic omitted, cycle_count tied to 16'h0000.
// TESTING  (MIN_CYCLES=4, TIMEOUT_CYC=16)
//  - Doors closed, Evacuated=0, begin_Evacuation 1 cycle; Evacuated=1 after 2 cycles ->
//    PumpOn high 4 cycles, Done pulse on 5th edge, back IDLE, cycle_count=1 (if _EN).
//  - From evacuated chamber, begin_Pressurize, Evacuated drops at cycle 6 -> ValveOpen
//    7 cycles, Done pulse, PumpOn never 1.
//  - begin_Evacuation with OuterClosed=0, and with both requests high -> Reject pulse, stay IDLE.
//  - EVAC with Evacuated held 0 -> Fault=1 after 16 cycles, PumpOn=0; ClearFault -> IDLE.
//  - InnerClosed drops at cycle 2 of EVAC -> FAULT; Abort+door-open same cycle -> IDLE, Fault=0.
//  - Reset asserted at cycle 3 of PRESS -> next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/airlock_cycle_ctrl_if.sv
// Request, sensor and drive bundle between the airlock controller and its surroundings.
// The controller side uses the slave modport; the sensor/request side uses master.
interface airlock_cycle_ctrl_if;
  logic        begin_Evacuation;
  logic        begin_Pressurize;
  logic        InnerClosed;
  logic        OuterClosed;
  logic        Evacuated;
  logic        Abort;
  logic        ClearFault;
  logic        PumpOn;
  logic        ValveOpen;
  logic        Busy;
  logic        Done;
  logic        Reject;
  logic        Fault;
  logic [15:0] cycle_count;

  modport master (
    output begin_Evacuation, begin_Pressurize, InnerClosed, OuterClosed,
           Evacuated, Abort, ClearFault,
    input  PumpOn, ValveOpen, Busy, Done, Reject, Fault, cycle_count
  );

  modport slave (
    input  begin_Evacuation, begin_Pressurize, InnerClosed, OuterClosed,
           Evacuated, Abort, ClearFault,
    output PumpOn, ValveOpen, Busy, Done, Reject, Fault, cycle_count
  );
endinterface

// File: rtl/airlock_cycle_ctrl.sv
// Airlock chamber controller: evacuate/pressurize cycles with door interlock, minimum run time and timeout.
// Define AIRLOCK_CYCLE_COUNT_EN to enable the saturating completed-cycle counter on cycle_count.
module airlock_cycle_ctrl #(
  parameter int CNT_W       = 8,
  parameter int MIN_CYCLES  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                Clock,
  input logic                Reset,
  airlock_cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EVAC, PRESS, DONE, FAULT} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] count, nextCount;
  logic             nextReject;
  logic             doorsClosed, minElapsed, timedOut, targetMet;
  logic             pumpOn, valveOpen, busy, done, reject, fault;

  assign doorsClosed = bus.InnerClosed & bus.OuterClosed;
  assign minElapsed  = (count >= CNT_W'(MIN_CYCLES - 1));
  assign timedOut    = (count == CNT_W'(TIMEOUT_CYC - 1));
  assign targetMet   = (state == EVAC) ? bus.Evacuated : !bus.Evacuated;

  // Next-state selection; the order of the EVAC/PRESS checks is the exit priority.
  always_comb begin
    nextState  = state;
    nextCount  = count;
    nextReject = 1'b0;
    case (state)
      IDLE: begin
        nextCount = '0;
        if (bus.begin_Evacuation && !bus.begin_Pressurize && doorsClosed && !bus.Evacuated)
          nextState = EVAC;
        else if (bus.begin_Pressurize && !bus.begin_Evacuation && doorsClosed && bus.Evacuated)
          nextState = PRESS;
        else if (bus.begin_Evacuation || bus.begin_Pressurize)
          nextReject = 1'b1;
      end
      EVAC, PRESS: begin
        nextCount = count + CNT_W'(1);
        if (bus.Abort)
          nextState = IDLE;
        else if (!doorsClosed)
          nextState = FAULT;
        else if (minElapsed && targetMet)
          nextState = DONE;
        else if (timedOut)
          nextState = FAULT;
      end
      DONE:    nextState = IDLE;
      FAULT:   if (bus.ClearFault) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from the next state so drives are valid in the first cycle of a state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      pumpOn    <= 1'b0;
      valveOpen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nextState;
      count     <= nextCount;
      pumpOn    <= (nextState == EVAC);
      valveOpen <= (nextState == PRESS);
      busy      <= (nextState == EVAC) || (nextState == PRESS);
      done      <= (nextState == DONE);
      reject    <= nextReject;
      fault     <= (nextState == FAULT);
    end
  end

  assign bus.PumpOn    = pumpOn;
  assign bus.ValveOpen = valveOpen;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Reject    = reject;
  assign bus.Fault     = fault;

`ifdef AIRLOCK_CYCLE_COUNT_EN
  logic [15:0] cycleCount;

  // DONE is only ever entered from EVAC/PRESS, so each entry is one completed cycle.
  always_ff @(posedge Clock) begin
    if (Reset)
      cycleCount <= 16'h0000;
    else if (nextState == DONE && state != DONE && cycleCount != 16'hFFFF)
      cycleCount <= cycleCount + 16'd1;
  end

  assign bus.cycle_count = cycleCount;
`else
  assign bus.cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_airlock_cycle_ctrl.sv
// Table-driven bench for airlock_cycle_ctrl (MIN_CYCLES=4, TIMEOUT_CYC=16).
// Each vector is one clock: inputs driven at negedge, expected outputs queued and checked after posedge.
module tb_airlock_cycle_ctrl;

  // Input field order:  {Reset, begin_Evacuation, begin_Pressurize, InnerClosed, OuterClosed, Evacuated, Abort, ClearFault}
  // Output field order: {PumpOn, ValveOpen, Busy, Done, Reject, Fault}
  typedef struct {
    bit [7:0] stim;
    bit [5:0] expOut;
    int       expCount;
    string    name;
  } vec_t;

`ifdef AIRLOCK_CYCLE_COUNT_EN
  localparam int COUNT_EN = 1;
`else
  localparam int COUNT_EN = 0;
`endif

  logic Clock;
  logic Reset;
  int   checks;
  int   passes;
  vec_t vecs[$];
  vec_t scoreboard[$];

  airlock_cycle_ctrl_if bus();

  airlock_cycle_ctrl #(
    .CNT_W      (8),
    .MIN_CYCLES (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void add(bit [7:0] stim, bit [5:0] expOut, string name, int expCount = -1);
    vec_t v;
    v.stim     = stim;
    v.expOut   = expOut;
    v.expCount = expCount;
    v.name     = name;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge Clock);
    Reset                = v.stim[7];
    bus.begin_Evacuation = v.stim[6];
    bus.begin_Pressurize = v.stim[5];
    bus.InnerClosed      = v.stim[4];
    bus.OuterClosed      = v.stim[3];
    bus.Evacuated        = v.stim[2];
    bus.Abort            = v.stim[1];
    bus.ClearFault       = v.stim[0];
    scoreboard.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t     e;
    bit [5:0] actual;
    checks++;
    if (scoreboard.size() == 0) begin
      $display("[TB] FAIL scoreboard: got empty queue, required a pending entry");
      return;
    end
    e      = scoreboard.pop_front();
    actual = {bus.PumpOn, bus.ValveOpen, bus.Busy, bus.Done, bus.Reject, bus.Fault};
    if (actual === e.expOut)
      passes++;
    else
      $display("[TB] FAIL %s: outputs got %b required %b", e.name, actual, e.expOut);
    if (e.expCount >= 0) begin
      checks++;
      if (bus.cycle_count === 16'(e.expCount))
        passes++;
      else
        $display("[TB] FAIL %s_count: cycle_count got %0d required %0d", e.name, bus.cycle_count, e.expCount);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    Reset  = 1'b1;
    bus.begin_Evacuation = 1'b0;
    bus.begin_Pressurize = 1'b0;
    bus.InnerClosed      = 1'b1;
    bus.OuterClosed      = 1'b1;
    bus.Evacuated        = 1'b0;
    bus.Abort            = 1'b0;
    bus.ClearFault       = 1'b0;

    // Reset and a normal evacuate: sensor reaches vacuum early and is ignored until the minimum time.
    add(8'b1_00_11_0_00, 6'b000000, "reset", 0);
    add(8'b0_00_11_0_00, 6'b000000, "idle");
    add(8'b0_10_11_0_00, 6'b101000, "evacStart");
    add(8'b0_00_11_0_00, 6'b101000, "evacCnt0");
    add(8'b0_00_11_0_00, 6'b101000, "evacCnt1");
    add(8'b0_00_11_1_00, 6'b101000, "evacEarlySensor");
    add(8'b0_00_11_1_00, 6'b000100, "evacDone", COUNT_EN);
    add(8'b0_00_11_1_00, 6'b000000, "evacBackIdle");

    // Pressurize from vacuum; sensor drops in the seventh cycle.
    add(8'b0_01_11_1_00, 6'b011000, "pressStart");
    for (int k = 0; k < 6; k++)
      add(8'b0_00_11_1_00, 6'b011000, "pressHold");
    add(8'b0_00_11_0_00, 6'b000100, "pressDone", 2 * COUNT_EN);
    add(8'b0_00_11_0_00, 6'b000000, "pressBackIdle");

    // Refused requests.
    add(8'b0_10_10_0_00, 6'b000010, "rejOuterOpen");
    add(8'b0_11_11_0_00, 6'b000010, "rejBothReq");
    add(8'b0_11_11_0_00, 6'b000010, "rejRepulse");
    add(8'b0_10_11_1_00, 6'b000010, "rejAlreadyVac");
    add(8'b0_00_11_0_00, 6'b000000, "rejReleased");

    // Timeout: sensor never reaches vacuum.
    add(8'b0_10_11_0_00, 6'b101000, "toStart");
    for (int k = 0; k < 15; k++)
      add(8'b0_00_11_0_00, 6'b101000, "toWait");
    add(8'b0_00_11_0_00, 6'b000001, "toFault");
    add(8'b0_10_11_0_00, 6'b000001, "faultIgnoresReq");
    add(8'b0_00_11_0_01, 6'b000000, "faultClear");

    // Door opens during evacuation.
    add(8'b0_10_11_0_00, 6'b101000, "doorStart");
    add(8'b0_00_11_0_00, 6'b101000, "doorCnt0");
    add(8'b0_00_11_0_00, 6'b101000, "doorCnt1");
    add(8'b0_00_01_0_00, 6'b000001, "doorInnerOpen");
    add(8'b0_00_11_0_01, 6'b000000, "doorClear");

    // Abort wins over a simultaneous door-open.
    add(8'b0_10_11_0_00, 6'b101000, "abortStart");
    add(8'b0_00_01_0_10, 6'b000000, "abortWithDoor");
    add(8'b0_00_11_0_00, 6'b000000, "abortIdle");

    // Reset in the middle of a pressurize cycle.
    add(8'b0_01_11_1_00, 6'b011000, "rstPressStart");
    add(8'b0_00_11_1_00, 6'b011000, "rstPressCnt0");
    add(8'b0_00_11_1_00, 6'b011000, "rstPressCnt1");
    add(8'b0_00_11_1_00, 6'b011000, "rstPressCnt2");
    add(8'b1_00_11_1_00, 6'b000000, "rstMidPress", 0);
    add(8'b0_00_11_1_00, 6'b000000, "rstIdle", 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge Clock);
      #1;
      checkOutput();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
